pixel_array_reader: RTL and testbench
=====================================

// Module: pixel_array_reader
// PURPOSE
//  Readout controller driving the row side of the pixel array: one-hot READ row select, captures the shared DATA_OUT bus.
//  Serializes each captured row into a pixel stream with valid/ready handshake, row-major, x=0 first.
//  Sits between the pixel array and the downstream frame buffer/output interface; one START reads exactly one frame.
// PARAMETERS
//  PIXEL_ARRAY_WIDTH   3  pixels per row (bus slices)
//  PIXEL_ARRAY_HEIGHT  3  rows; width of READ
//  PIXEL_BITS          8  bits per pixel
//  SETTLE_CYCLES       1  cycles READ is held before capture (>=1), covers tri-state bus settling
// PORTS
//  CLK          in   1      single clock, all state on rising edge
//  RESET_N      in   1      asynchronous, active-low reset
//  START        in   1      frame request, sampled only in IDLE
//  BUSY         out  1      high from first cycle after accepted START until DONE cycle inclusive
//  DONE         out  1      one-cycle pulse after last pixel handshake
//  READ         out  H      one-hot row select to array; all zero outside SELECT/CAPTURE
//  DATA_IN      in   W*B    array DATA_OUT bus; pixel x at [x*B +: B]
//  PIXEL_DATA   out  B      current pixel value
//  PIXEL_X      out  clog2(W)  column of current pixel
//  PIXEL_Y      out  clog2(H)  row of current pixel
//  PIXEL_LAST   out  1      high with VALID on pixel (W-1,H-1)
//  PIXEL_VALID  out  1      stream valid
//  PIXEL_READY  in   1      stream ready; transfer when VALID&&READY on rising edge
// BEHAVIOUR
//  Reset (async assert, sync-safe release): state IDLE, READ=0, PIXEL_VALID=0, BUSY=0, DONE=0, data/X/Y=0.
//  FSM: IDLE -> SELECT -> CAPTURE -> STREAM -> (SELECT next row | FINISH) -> IDLE.
//  IDLE: START=1 -> SELECT, row=0, settle counter=0. START=0 -> stay.
//  SELECT: READ=1<<row; stays SELECT_CYCLES=SETTLE_CYCLES cycles, then CAPTURE.
//  CAPTURE: READ still asserted; DATA_IN latched into row register at end of cycle; -> STREAM, col=0.
//  STREAM: READ=0; PIXEL_VALID=1; PIXEL_DATA=row_reg[col*B +: B], X=col, Y=row.
//   Handshake: on VALID&&READY col++; on col==W-1 transfer: row<H-1 -> SELECT(row+1), else FINISH.
//   READY=0: VALID, DATA, X, Y, LAST held stable; VALID never drops without a transfer.
//  FINISH: DONE=1, BUSY=1, VALID=0 for one cycle -> IDLE.
//  Latency: START sampled at edge 0 -> READ high edges 1..SETTLE_CYCLES+1 -> first VALID after edge SETTLE_CYCLES+2.
//  Row period with READY=1: SETTLE_CYCLES+1+W cycles; READ is zero >=1 cycle between rows (break-before-make).
//  DATA_IN only sampled in CAPTURE; Z/X on bus other cycles is ignored.
//  START while BUSY ignored (no queuing). START held high: new frame accepted in first IDLE cycle after FINISH.
//  Reset mid-frame: READ, VALID drop immediately; partial frame discarded; next START restarts at row 0, no DONE issued.
//  Counters wrap only by FSM control; col/row never exceed W-1/H-1.
// STRUCTURE
//  pixel_array_pkg: PIXEL_ARRAY_WIDTH, PIXEL_ARRAY_HEIGHT, PIXEL_BITS, shared with PIXEL_ARRAY;
//   state enum (IDLE, SELECT, CAPTURE, STREAM, FINISH).
//  Sub-module pixel_row_serializer: row register load + column mux + valid/ready + LAST; FSM and READ in top.
// TESTING (defaults unless stated; bench models array: row r pixel x = 16*r+x, bus Z when no READ)
//  1 RESET_N=0 mid-anything -> READ=000, VALID=0, BUSY=0, DONE=0 without a clock edge.
//  2 START pulse, READY=1 -> READ 001,010,100 each for 2 cycles; stream 00,01,02,10,11,12,20,21,22;
//    LAST only on 0x22; DONE one cycle later; 15 cycles START-edge to last transfer.
//  3 READY=0 for 4 cycles on pixel 0x11 -> DATA=0x11, X=1, Y=1, VALID=1 stable; resumes with 0x12, none lost/duplicated.
//  4 START pulsed during STREAM row 1 -> ignored, single DONE; START held high -> back-to-back frames, both complete.
//  5 RESET_N low during STREAM row 1 then START -> READ=001 first, stream restarts at 0x00, no DONE for aborted frame.
//  6 SETTLE_CYCLES=3 -> each READ one-hot held 4 cycles; capture only in 4th; first VALID after edge 5.

Source files
------------

// File: rtl/pixel_array_pkg.sv
// Shared geometry of the pixel array and the readout FSM state encoding.
package pixel_array_pkg;

  localparam int PIXEL_ARRAY_WIDTH  = 3;
  localparam int PIXEL_ARRAY_HEIGHT = 3;
  localparam int PIXEL_BITS         = 8;

  // Readout FSM states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SELECT  = 3'd1;
  localparam state_t ST_CAPTURE = 3'd2;
  localparam state_t ST_STREAM  = 3'd3;
  localparam state_t ST_FINISH  = 3'd4;

  // Index width for a counter over n positions; never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_row_serializer.sv
// Holds one captured row and presents it as a valid/ready pixel stream, x=0 first.
module pixel_row_serializer #(
  parameter int WIDTH = 3,
  parameter int BITS  = 8,
  parameter int COL_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [WIDTH*BITS-1:0]  row_in,
  input  logic                   last_row,
  input  logic                   ready,
  output logic [BITS-1:0]        data,
  output logic [COL_W-1:0]       x,
  output logic                   valid,
  output logic                   last,
  output logic                   row_done
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);

  logic [WIDTH*BITS-1:0] row_reg;
  logic                  xfer;
  logic                  at_end;

  assign xfer     = valid && ready;
  assign at_end   = (x == COL_LAST);
  assign row_done = xfer && at_end;
  assign last     = valid && at_end && last_row;

  // Column mux: select the pixel slice addressed by the current column
  always_comb begin
    data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x == COL_W'(i)) data = row_reg[i*BITS +: BITS];
    end
  end

  // Row load and column advance; valid stays up until the last column transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg <= '0;
      x       <= '0;
      valid   <= 1'b0;
    end else if (load) begin
      row_reg <= row_in;
      x       <= '0;
      valid   <= 1'b1;
    end else if (xfer) begin
      if (at_end) valid <= 1'b0;
      else        x     <= x + COL_W'(1);
    end
  end

endmodule

// File: rtl/pixel_array_reader.sv
// Row-side readout controller: selects one row at a time, lets the shared bus
// settle, captures it and hands it to the serializer. One START = one frame.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  IDLE    | waiting for START; READ low, no stream
//  SELECT  | READ one-hot on current row, settle counter running down
//  CAPTURE | READ still on; bus latched into the row register at cycle end
//  STREAM  | READ low; serializer presenting the row's pixels
//  FINISH  | one-cycle DONE pulse, then back to IDLE
module pixel_array_reader #(
  parameter int PIXEL_ARRAY_WIDTH  = pixel_array_pkg::PIXEL_ARRAY_WIDTH,
  parameter int PIXEL_ARRAY_HEIGHT = pixel_array_pkg::PIXEL_ARRAY_HEIGHT,
  parameter int PIXEL_BITS         = pixel_array_pkg::PIXEL_BITS,
  parameter int SETTLE_CYCLES      = 1,
  localparam int COL_W = pixel_array_pkg::idx_bits(PIXEL_ARRAY_WIDTH),
  localparam int ROW_W = pixel_array_pkg::idx_bits(PIXEL_ARRAY_HEIGHT)
) (
  input  logic                                    CLK,
  input  logic                                    RESET_N,
  input  logic                                    START,
  output logic                                    BUSY,
  output logic                                    DONE,
  output logic [PIXEL_ARRAY_HEIGHT-1:0]           READ,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] DATA_IN,
  output logic [PIXEL_BITS-1:0]                   PIXEL_DATA,
  output logic [COL_W-1:0]                        PIXEL_X,
  output logic [ROW_W-1:0]                        PIXEL_Y,
  output logic                                    PIXEL_LAST,
  output logic                                    PIXEL_VALID,
  input  logic                                    PIXEL_READY
);

  import pixel_array_pkg::*;

  localparam int CNT_W = idx_bits(SETTLE_CYCLES);
  localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [ROW_W-1:0] row;
  logic [CNT_W-1:0] settle_cnt;
  logic             selecting;
  logic             load;
  logic             last_row;
  logic             row_done;

  assign selecting = (state == ST_SELECT) || (state == ST_CAPTURE);
  assign load      = (state == ST_CAPTURE);
  assign last_row  = (row == ROW_LAST);
  assign BUSY      = (state != ST_IDLE);
  assign DONE      = (state == ST_FINISH);
  assign PIXEL_Y   = row;

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (START) state_nxt = ST_SELECT;
      ST_SELECT:  if (settle_cnt == '0) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_STREAM;
      ST_STREAM:  if (row_done) state_nxt = last_row ? ST_FINISH : ST_SELECT;
      ST_FINISH:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State register; async reset drops READ and VALID without waiting for a clock
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Row index and settle down-counter, reloaded on each row entry into SELECT
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      row        <= '0;
      settle_cnt <= '0;
    end else if (state == ST_IDLE && START) begin
      row        <= '0;
      settle_cnt <= SETTLE_LOAD;
    end else if (state == ST_STREAM && row_done && !last_row) begin
      row        <= row + ROW_W'(1);
      settle_cnt <= SETTLE_LOAD;
    end else if (state == ST_SELECT && settle_cnt != '0) begin
      settle_cnt <= settle_cnt - CNT_W'(1);
    end
  end

  // One-hot row select, only while selecting or capturing
  always_comb begin
    READ = '0;
    for (int i = 0; i < PIXEL_ARRAY_HEIGHT; i++) begin
      READ[i] = selecting && (row == ROW_W'(i));
    end
  end

  pixel_row_serializer #(
    .WIDTH (PIXEL_ARRAY_WIDTH),
    .BITS  (PIXEL_BITS),
    .COL_W (COL_W)
  ) u_serializer (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .load     (load),
    .row_in   (DATA_IN),
    .last_row (last_row),
    .ready    (PIXEL_READY),
    .data     (PIXEL_DATA),
    .x        (PIXEL_X),
    .valid    (PIXEL_VALID),
    .last     (PIXEL_LAST),
    .row_done (row_done)
  );

endmodule

// File: tb/tb_pixel_array_reader.sv
// Bench for pixel_array_reader: models a 3x3 array (pixel = 16*row + col) whose
// bus only carries real data once READ has been stable for the settle time.
module tb_pixel_array_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;

  // DUT with default settle time
  logic        start, busy, done, last, valid, ready;
  logic [2:0]  rd;
  logic [23:0] bus;
  logic [7:0]  pdata;
  logic [1:0]  px, py;

  // DUT with SETTLE_CYCLES=3
  logic        start3, busy3, done3, last3, valid3, ready3;
  logic [2:0]  rd3;
  logic [23:0] bus3;
  logic [7:0]  pdata3;
  logic [1:0]  px3, py3;

  always #5 clk = ~clk;

  pixel_array_reader dut (
    .CLK(clk), .RESET_N(rst_n), .START(start), .BUSY(busy), .DONE(done),
    .READ(rd), .DATA_IN(bus), .PIXEL_DATA(pdata), .PIXEL_X(px), .PIXEL_Y(py),
    .PIXEL_LAST(last), .PIXEL_VALID(valid), .PIXEL_READY(ready)
  );

  pixel_array_reader #(.SETTLE_CYCLES(3)) dut3 (
    .CLK(clk), .RESET_N(rst_n), .START(start3), .BUSY(busy3), .DONE(done3),
    .READ(rd3), .DATA_IN(bus3), .PIXEL_DATA(pdata3), .PIXEL_X(px3), .PIXEL_Y(py3),
    .PIXEL_LAST(last3), .PIXEL_VALID(valid3), .PIXEL_READY(ready3)
  );

  // ---------------- pixel array model ----------------
  function automatic logic [23:0] row_bus(input int r);
    logic [23:0] v;
    for (int x = 0; x < 3; x++) v[x*8 +: 8] = 8'(16*r + x);
    return v;
  endfunction

  int       age, age3;
  logic [2:0] last_rd, last_rd3;

  always @(posedge clk) begin
    if (rd == 3'b000)       age <= 0;
    else if (rd == last_rd) age <= age + 1;
    else                    age <= 1;
    last_rd <= rd;
    if (rd3 == 3'b000)        age3 <= 0;
    else if (rd3 == last_rd3) age3 <= age3 + 1;
    else                      age3 <= 1;
    last_rd3 <= rd3;
  end

  // Unsettled or unselected bus reads as junk so early/late capture shows up
  always_comb begin
    bus  = {3{8'hEE}};
    bus3 = {3{8'hEE}};
    for (int r = 0; r < 3; r++) begin
      if (age  >= 1 && rd  == 3'(1 << r)) bus  = row_bus(r);
      if (age3 >= 3 && rd3 == 3'(1 << r)) bus3 = row_bus(r);
    end
  end

  // ---------------- scoreboard ----------------
  // entry = {last, y, x, data}
  logic [12:0] q[$];
  logic [12:0] q3[$];
  bit          expect_done = 0;
  bit          hold_pending = 0;
  logic [12:0] held;
  int          done_cnt = 0;

  task automatic push_frame(input bit to3);
    for (int r = 0; r < 3; r++)
      for (int x = 0; x < 3; x++) begin
        if (to3) q3.push_back({(r == 2 && x == 2), 2'(r), 2'(x), 8'(16*r + x)});
        else     q.push_back ({(r == 2 && x == 2), 2'(r), 2'(x), 8'(16*r + x)});
      end
  endtask

  // Monitor for the default DUT: pixel order/content, DONE timing, stall stability
  always @(negedge clk) begin
    logic [12:0] cur, exp_e;
    if (rst_n) begin
      cur = {last, py, px, pdata};
      if (done) done_cnt++;
      if (expect_done) begin
        checks++;
        if (!done) begin
          errors++;
          $display("FAIL done_after_last: done=%0b required 1", done);
        end
        expect_done = 0;
      end else if (done) begin
        checks++; errors++;
        $display("FAIL unexpected_done: done=1 required 0");
      end
      if (hold_pending) begin
        checks++;
        if (!valid || cur != held) begin
          errors++;
          $display("FAIL stall_stable: valid=%0b entry=%h required valid=1 entry=%h", valid, cur, held);
        end
      end
      hold_pending = valid && !ready;
      held = cur;
      if (valid && ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: entry=%h required none", cur);
        end else begin
          exp_e = q.pop_front();
          if (cur != exp_e) begin
            errors++;
            $display("FAIL pixel: last/y/x/data=%h required %h", cur, exp_e);
          end
        end
        if (last) expect_done = 1;
      end
    end
  end

  // Monitor for the long-settle DUT
  always @(negedge clk) begin
    logic [12:0] cur3, exp3;
    if (rst_n && valid3 && ready3) begin
      cur3 = {last3, py3, px3, pdata3};
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pixel3: entry=%h required none", cur3);
      end else begin
        exp3 = q3.pop_front();
        if (cur3 != exp3) begin
          errors++;
          $display("FAIL pixel3: last/y/x/data=%h required %h", cur3, exp3);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pixel(input int y, input int d);
    int n = 0;
    while (!(valid && py == 2'(y) && pdata == 8'(d)) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL wait_pixel_timeout: pixel %0h not seen, required within 100 cycles", d);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL wait_done_timeout: done=0 required 1 within 100 cycles");
    end
  endtask

  task automatic do_reset_async();
    rst_n = 1'b0;
    #1;
    check("rst_read", int'(rd), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    q.delete();
    expect_done  = 0;
    hold_pending = 0;
    tick();
    rst_n = 1'b1;
  endtask

  // Expected per-cycle trace after the START edge, default settle
  localparam logic [2:0] EXP_READ [17] = '{1,1,0,0,0, 2,2,0,0,0, 4,4,0,0,0, 0,0};
  localparam bit         EXP_VALID[17] = '{0,0,1,1,1, 0,0,1,1,1, 0,0,1,1,1, 0,0};

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    rst_n = 1'b0; start = 0; start3 = 0; ready = 1; ready3 = 1;
    repeat (3) tick();
    check("init_read", int'(rd), 0);
    check("init_valid", int'(valid), 0);
    check("init_busy", int'(busy), 0);
    check("init_done", int'(done), 0);
    check("init_data", int'({pdata, px, py}), 0);
    rst_n = 1'b1;
    tick();

    // Full frame with READY=1: cycle-exact READ/VALID/BUSY/DONE trace
    push_frame(0);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      check($sformatf("trace_read_c%0d", c), int'(rd), int'(EXP_READ[c]));
      check($sformatf("trace_valid_c%0d", c), int'(valid), int'(EXP_VALID[c]));
      check($sformatf("trace_done_c%0d", c), int'(done), (c == 15) ? 1 : 0);
      check($sformatf("trace_busy_c%0d", c), int'(busy), (c <= 15) ? 1 : 0);
    end
    tick();

    // Stall on pixel 0x11 for four cycles
    push_frame(0);
    start = 1; tick(); start = 0;
    wait_pixel(1, 'h11);
    ready = 0;
    repeat (4) begin
      tick();
      check("stall_data", int'(pdata), 'h11);
      check("stall_xy", int'({px, py}), 'b0101);
      check("stall_valid", int'(valid), 1);
    end
    ready = 1;
    tick();
    check("resume_data", int'(pdata), 'h12);
    wait_done();
    tick();

    // START during row 1 is ignored
    d0 = done_cnt;
    push_frame(0);
    start = 1; tick(); start = 0;
    wait_pixel(1, 'h10);
    start = 1; tick(); start = 0;
    wait_done();
    repeat (12) tick();
    check("ignored_start_dones", done_cnt - d0, 1);
    check("ignored_start_busy", int'(busy), 0);

    // START held high: back-to-back frames
    push_frame(0);
    push_frame(0);
    start = 1;
    wait_done();
    tick();
    check("b2b_idle_busy", int'(busy), 0);
    tick();
    check("b2b_restart_busy", int'(busy), 1);
    start = 0;
    wait_done();
    repeat (3) tick();
    check("b2b_queue_empty", q.size(), 0);

    // Reset while selecting row 0
    push_frame(0);
    start = 1; tick(); start = 0;
    check("sel_read", int'(rd), 1);
    #2 do_reset_async();
    tick();

    // Reset during row 1 stream, then restart from row 0
    push_frame(0);
    start = 1; tick(); start = 0;
    wait_pixel(1, 'h11);
    #3 do_reset_async();
    tick();
    d0 = done_cnt;
    push_frame(0);
    start = 1; tick(); start = 0;
    check("restart_read", int'(rd), 1);
    wait_done();
    repeat (3) tick();
    check("restart_dones", done_cnt - d0, 1);
    check("restart_queue_empty", q.size(), 0);

    // Long settle: READ held four cycles per row, 7-cycle row period
    push_frame(1);
    start3 = 1;
    @(posedge clk);
    #1 start3 = 0;
    for (int c = 0; c < 23; c++) begin
      int r, p;
      r = c / 7;
      p = c % 7;
      @(negedge clk);
      check($sformatf("s3_read_c%0d", c), int'(rd3), (c < 21 && p <= 3) ? (1 << r) : 0);
      check($sformatf("s3_valid_c%0d", c), int'(valid3), (c < 21 && p >= 4) ? 1 : 0);
      check($sformatf("s3_done_c%0d", c), int'(done3), (c == 21) ? 1 : 0);
    end
    tick();
    check("s3_queue_empty", q3.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required to finish earlier");
    $fatal(1);
  end

endmodule
